// File: rtl/pbch_re_extractor.sv
// pbch_re_extractor
//   Extracts the PBCH resource elements of one SSB from a streaming FFT output
//   (4 OFDM symbols x 256 bins, natural order) and tags each RE as DMRS or data.
//   Symbol 0 (PSS) is skipped. Symbols 1 and 3 contribute SSB subcarriers 0..239.
//   Symbol 2 contributes subcarriers 0..47 and 192..239, which skips SSS and its guard.
//   The DMRS position is v = N_id mod 4.
//
// Handshake: valid-only streaming. A beat is transferred on every clock where
//   s_axis_in_tvalid=1. There is no tready in either direction. The downstream
//   block must accept every beat on which m_axis_out_tvalid=1.
//
// Ports:
//   clk_i, reset_i      clock, asynchronous active-high reset
//   s_axis_in_tdata     FFT bin sample (I upper half, Q lower half)
//   s_axis_in_tvalid    input beat valid
//   SSB_start_i         marks the beat carrying bin 0 of SSB symbol 0
//   N_id_i/N_id_valid_i cell ID and its strobe
//   m_axis_out_*        selected PBCH RE. tuser=1 for DMRS. tlast on the 576th RE.
//   PBCH_start_o        asserted with the first output RE of an SSB
//   overrun_o           one-cycle pulse when a new SSB start aborts the current one
//
// Optional: define PBCH_RE_EXTRACT_DEBUG_EN to add debug_k_o / debug_sym_o,
//   which are registered alongside the output data.
module pbch_re_extractor #(
    parameter int IN_DW       = 32,
    parameter int NFFT        = 8,
    parameter int MAX_CELL_ID = 1007,
    parameter int SSB_OFFSET  = 8
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic [IN_DW-1:0]               s_axis_in_tdata,
    input  logic                           s_axis_in_tvalid,
    input  logic                           SSB_start_i,
    input  logic [$clog2(MAX_CELL_ID)-1:0] N_id_i,
    input  logic                           N_id_valid_i,
    output logic [IN_DW-1:0]               m_axis_out_tdata,
    output logic                           m_axis_out_tvalid,
    output logic                           m_axis_out_tuser,
    output logic                           m_axis_out_tlast,
    output logic                           PBCH_start_o,
    output logic                           overrun_o
`ifdef PBCH_RE_EXTRACT_DEBUG_EN
    ,
    output logic [7:0]                     debug_k_o,
    output logic [1:0]                     debug_sym_o
`endif
);

    localparam int NIDW = $clog2(MAX_CELL_ID);
    localparam int KW   = NFFT + 1;

    // Subcarrier bounds, expressed as signed k values.
    localparam logic signed [KW-1:0] K_ZERO       = '0;
    localparam logic signed [KW-1:0] K_MAX        = KW'(239);
    localparam logic signed [KW-1:0] K_S2_LO_END  = KW'(47);
    localparam logic signed [KW-1:0] K_S2_HI_BEG  = KW'(192);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SKIP_PSS = 2'd1,
        ST_PBCH     = 2'd2
    } state_t;

    state_t            r_state;
    logic [NFFT-1:0]   r_bin_cnt;
    logic [1:0]        r_sym_cnt;
    logic [NIDW-1:0]   r_nid_pending;
    logic              r_nid_seen;
    logic [1:0]        r_v_active;

    logic signed [KW-1:0] w_k;
    logic                 w_start;
    logic                 w_last_bin;
    logic                 w_in_sym13;
    logic                 w_in_sym2;
    logic                 w_sel;
    logic                 w_nid_unused;

    // k is signed, so bins below SSB_OFFSET come out negative and are rejected.
    assign w_k        = signed'({1'b0, r_bin_cnt}) - signed'(KW'(SSB_OFFSET));
    assign w_start    = SSB_start_i & s_axis_in_tvalid & r_nid_seen;
    assign w_last_bin = (r_bin_cnt == '1);
    assign w_in_sym13 = (w_k >= K_ZERO) && (w_k <= K_MAX);
    assign w_in_sym2  = w_in_sym13 && ((w_k <= K_S2_LO_END) || (w_k >= K_S2_HI_BEG));
    assign w_sel      = (r_state == ST_PBCH) &&
                        ((r_sym_cnt == 2'd2) ? w_in_sym2 : w_in_sym13);

    // Only the low two bits of N_id select the DMRS position. The full ID is kept
    // in the pending register.
    assign w_nid_unused = ^r_nid_pending[NIDW-1:2];

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state           <= ST_IDLE;
            r_bin_cnt         <= '0;
            r_sym_cnt         <= '0;
            r_nid_pending     <= '0;
            r_nid_seen        <= 1'b0;
            r_v_active        <= '0;
            m_axis_out_tdata  <= '0;
            m_axis_out_tvalid <= 1'b0;
            m_axis_out_tuser  <= 1'b0;
            m_axis_out_tlast  <= 1'b0;
            PBCH_start_o      <= 1'b0;
            overrun_o         <= 1'b0;
`ifdef PBCH_RE_EXTRACT_DEBUG_EN
            debug_k_o         <= '0;
            debug_sym_o       <= '0;
`endif
        end else begin
            m_axis_out_tvalid <= 1'b0;
            m_axis_out_tuser  <= 1'b0;
            m_axis_out_tlast  <= 1'b0;
            PBCH_start_o      <= 1'b0;
            overrun_o         <= 1'b0;

            if (N_id_valid_i) begin
                r_nid_pending <= N_id_i;
                r_nid_seen    <= 1'b1;
            end

            if (w_start) begin
                // The start beat is bin 0 of symbol 0. A start seen while an SSB
                // is still in progress abandons that SSB without emitting tlast.
                overrun_o  <= (r_state != ST_IDLE);
                r_state    <= ST_SKIP_PSS;
                r_bin_cnt  <= NFFT'(1);
                r_sym_cnt  <= 2'd0;
                r_v_active <= r_nid_pending[1:0];
            end else if (s_axis_in_tvalid) begin
                case (r_state)
                    ST_IDLE: begin
                    end
                    ST_SKIP_PSS: begin
                        r_bin_cnt <= r_bin_cnt + NFFT'(1);
                        if (w_last_bin) begin
                            r_sym_cnt <= 2'd1;
                            r_state   <= ST_PBCH;
                        end
                    end
                    ST_PBCH: begin
                        r_bin_cnt <= r_bin_cnt + NFFT'(1);
                        if (w_sel) begin
                            m_axis_out_tvalid <= 1'b1;
                            m_axis_out_tdata  <= s_axis_in_tdata;
                            m_axis_out_tuser  <= (w_k[1:0] == r_v_active);
                            m_axis_out_tlast  <= (r_sym_cnt == 2'd3) && (w_k == K_MAX);
                            PBCH_start_o      <= (r_sym_cnt == 2'd1) && (w_k == K_ZERO);
`ifdef PBCH_RE_EXTRACT_DEBUG_EN
                            debug_k_o         <= w_k[7:0];
                            debug_sym_o       <= r_sym_cnt;
`endif
                        end
                        if (w_last_bin) begin
                            if (r_sym_cnt == 2'd3) begin
                                r_sym_cnt <= 2'd0;
                                r_state   <= ST_IDLE;
                            end else begin
                                r_sym_cnt <= r_sym_cnt + 2'd1;
                            end
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/pbch_re_extractor.md
Name: pbch_re_extractor

Overview:
- Sits directly upstream of the channel estimator. Consumes the FFT output stream of one SSB, which is 4 OFDM symbols of 256 bins each.
- Selects the PBCH resource elements and tags each one as DMRS or data. DMRS positions follow v = N_id mod 4.
- Generates the PBCH start pulse that aligns the downstream DMRS comparison.
- Streaming only, no backpressure.

Parameters:
- IN_DW, 32, IQ sample width; I in the upper half, Q in the lower half; passed through unchanged.
- NFFT, 8, log2 of FFT length. FFT_LEN = 256 is fixed for this block.
- MAX_CELL_ID, 1007, maximum N_id.
- SSB_OFFSET, 8, FFT bin that holds SSB subcarrier k=0. Bin = k + SSB_OFFSET, k = 0..239.

Ports:
- clk_i  in  1  clock
- reset_i  in  1  asynchronous, active-high reset
- s_axis_in_tdata  in  IN_DW  FFT bin sample, natural (fftshifted) order, bins 0..255 per symbol
- s_axis_in_tvalid  in  1  sample valid
- SSB_start_i  in  1  pulse coincident with the valid beat of bin 0 of SSB symbol 0 (PSS)
- N_id_i  in  $clog2(MAX_CELL_ID)  cell ID
- N_id_valid_i  in  1  N_id strobe
- m_axis_out_tdata  out  IN_DW  PBCH RE
- m_axis_out_tvalid  out  1  RE valid
- m_axis_out_tuser  out  1  1 = DMRS RE, 0 = PBCH data RE
- m_axis_out_tlast  out  1  last RE of the SSB (576th beat)
- PBCH_start_o  out  1  pulse with the first output RE of each SSB
- overrun_o  out  1  one-cycle pulse when an SSB is aborted by a new SSB_start_i

Behaviour:
- Reset values: all outputs 0; state IDLE; counters 0; N_id_valid_seen 0.
- N_id handling:
  - N_id_i is captured into N_id_pending on N_id_valid_i, and N_id_valid_seen is set.
  - v = N_id_pending[1:0] is latched into v_active only when SSB_start_i is accepted. An N_id change mid-SSB takes effect at the next SSB.
- Counters: bin_cnt (0..255) and sym_cnt (0..3) advance only on input beats with s_axis_in_tvalid=1. Gaps in tvalid stall everything with no output.
- FSM:
  - IDLE: on SSB_start_i & tvalid & N_id_valid_seen, go to SKIP_PSS. That beat counts as bin 0 of symbol 0. SSB_start_i before any N_id is ignored.
  - SKIP_PSS: no output. After bin 255, go to PBCH with sym_cnt = 1.
  - PBCH: with k = bin_cnt - SSB_OFFSET, a beat is selected when:
    - sym 1 or 3: 0 <= k <= 239;
    - sym 2: 0 <= k <= 47 or 192 <= k <= 239. SSS and its guard are skipped.
  - PBCH, DMRS tagging: tuser = (k[1:0] == v_active).
  - PBCH, exit: after bin 255 of symbol 3, return to IDLE.
- Output counts per SSB: 576 REs = 240 + 96 + 240, of which 144 are DMRS (60 + 24 + 60) and 432 are data.
- Output timing:
  - Latency is 1 cycle: a selected input beat appears registered on the next clock. Unselected beats produce tvalid=0.
  - PBCH_start_o = 1 on the same cycle as the first output beat (sym 1, k = 0).
  - tlast = 1 on sym 3, k = 239.
- Abort and restart:
  - SSB_start_i & tvalid while in SKIP_PSS or PBCH aborts the current SSB: no tlast for it, overrun_o pulses 1 cycle.
  - The aborting beat is treated as bin 0 of symbol 0 of the new SSB, with v re-latched.
- SSB_start_i without tvalid is ignored in every state.
- Async reset mid-SSB: outputs drop to 0 immediately, FSM returns to IDLE, N_id_valid_seen is cleared. A new N_id is required before the next SSB.
- Width rules: k is computed as a signed (NFFT+1)-bit value, so bins below SSB_OFFSET are negative and therefore not selected. Data passes through unmodified.

Optional Feature:
- Macro PBCH_RE_EXTRACT_DEBUG_EN.
- Defined: adds outputs debug_k_o (8 bit, SSB subcarrier of the current output beat) and debug_sym_o (2 bit, symbol 1..3), registered alongside m_axis_out_tdata; both reset to 0.
- Not defined: these ports and their registers do not exist; all other behaviour is identical.

Test Plan:
- N_id=0, one SSB streamed back-to-back with data = bin index → 576 outputs, 144 with tuser=1. First output is bin 8 with tuser=1 and PBCH_start_o=1. tlast is on bin 247 of symbol 3.
- N_id=209 (v=1) → symbol 1 first DMRS is the 2nd output (k=1, bin 9). Symbol 2 outputs are bins 8..55 and 200..247, with DMRS at k = 1, 5, ..., 237.
- Same SSB with a random 30% tvalid gap pattern → output sequence and tags identical to the gap-free run; each output follows its input beat by exactly 1 cycle.
- SSB_start_i before any N_id_valid_i → no output. Then N_id=3 followed by SSB_start → normal SSB with v=3.
- SSB_start_i in symbol 2 bin 100 → overrun_o pulse, no tlast for the aborted SSB. The new SSB yields a full 576 REs.
- N_id changed from 0 to 2 mid-SSB → current SSB DMRS at k mod 4 = 0; next SSB at k mod 4 = 2.
- reset_i asserted mid symbol 3 → all outputs 0 within the same cycle, and no output until a new N_id and SSB_start.
